// File: rtl/full_adder_reg.sv
// Registered WIDTH-bit ripple-carry adder: {count,sum} = in_1 + in_2 + cin, one cycle latency.
// Optional signed-overflow output ovf is enabled by defining FULL_ADDER_OVF_EN.
module full_adder_reg #(
    parameter int WIDTH = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             count
`ifdef FULL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Single-bit full-adder cell equations.
    function automatic logic fa_sum(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // carry_s[i] is the carry into cell i; carry_s[WIDTH] is the final carry-out.
    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] sum_s;

    assign carry_s[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign sum_s[i]       = fa_sum(in_1[i], in_2[i], carry_s[i]);
        assign carry_s[i + 1] = fa_carry(in_1[i], in_2[i], carry_s[i]);
    end

    // Result registers: capture on in_valid, otherwise hold data and drop valid.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sum       <= {WIDTH{1'b0}};
            count     <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            sum       <= sum_s;
            count     <= carry_s[WIDTH];
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef FULL_ADDER_OVF_EN
    // Signed overflow is the carry into the MSB differing from the carry out of it.
    logic ovf_s;
    assign ovf_s = carry_s[WIDTH] ^ carry_s[WIDTH - 1];

    // Overflow flag register, updated alongside sum.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= ovf_s;
        end else begin
            ovf <= ovf;
        end
    end
`endif

endmodule

// File: tb/tb_full_adder_reg.sv
// Directed and randomised checks of full_adder_reg at WIDTH = 1, 4 and 8.
// Overflow checks are included when FULL_ADDER_OVF_EN is defined.
module tb_full_adder_reg;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
    logic       ov1, s1, co1;
    logic       v4 = 1'b0, c4 = 1'b0;
    logic [3:0] a4 = 4'h0, b4 = 4'h0;
    logic       ov4, co4;
    logic [3:0] s4;
    logic       v8 = 1'b0, c8 = 1'b0;
    logic [7:0] a8 = 8'h00, b8 = 8'h00;
    logic       ov8, co8;
    logic [7:0] s8;
`ifdef FULL_ADDER_OVF_EN
    logic of1, of4, of8;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    full_adder_reg #(.WIDTH(1)) u_w1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(v1), .in_1(a1), .in_2(b1),
        .cin(c1), .out_valid(ov1), .sum(s1), .count(co1)
`ifdef FULL_ADDER_OVF_EN
        , .ovf(of1)
`endif
    );

    full_adder_reg #(.WIDTH(4)) u_w4 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(v4), .in_1(a4), .in_2(b4),
        .cin(c4), .out_valid(ov4), .sum(s4), .count(co4)
`ifdef FULL_ADDER_OVF_EN
        , .ovf(of4)
`endif
    );

    full_adder_reg #(.WIDTH(8)) u_w8 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .in_valid(v8), .in_1(a8), .in_2(b8),
        .cin(c8), .out_valid(ov8), .sum(s8), .count(co8)
`ifdef FULL_ADDER_OVF_EN
        , .ovf(of8)
`endif
    );

    task automatic check_value(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    logic [8:0] exp8;
    logic [8:0] res8;
    logic       exp_v8;
    logic [2:0] vec;
    logic [1:0] exp1;

    initial begin
        // Reset state, with edges occurring while reset is held
        repeat (3) step();
        check_value("rst_w1", {61'd0, ov1, co1, s1}, 64'd0);
        check_value("rst_w4", {58'd0, ov4, co4, s4}, 64'd0);
        check_value("rst_w8", {54'd0, ov8, co8, s8}, 64'd0);
`ifdef FULL_ADDER_OVF_EN
        check_value("rst_ovf", {61'd0, of1, of4, of8}, 64'd0);
`endif
        @(negedge sys_clk);
        sys_rst = 1'b0;

        // WIDTH=1 exhaustive truth table
        for (int i = 0; i < 8; i++) begin
            vec = i[2:0];
            {a1, b1, c1} = vec;
            v1 = 1'b1;
            case (vec)
                3'b000:  exp1 = 2'b00;
                3'b001:  exp1 = 2'b01;
                3'b010:  exp1 = 2'b01;
                3'b011:  exp1 = 2'b10;
                3'b100:  exp1 = 2'b01;
                3'b101:  exp1 = 2'b10;
                3'b110:  exp1 = 2'b10;
                default: exp1 = 2'b11;
            endcase
            step();
            check_value($sformatf("w1_sum_%0d", i), {62'd0, co1, s1}, {62'd0, exp1});
            check_value($sformatf("w1_vld_%0d", i), {63'd0, ov1}, 64'd1);
        end
        v1 = 1'b0;
        step();
        check_value("w1_vld_drop", {63'd0, ov1}, 64'd0);

        // WIDTH=4 carry-out boundaries
        a4 = 4'hF; b4 = 4'h1; c4 = 1'b0; v4 = 1'b1;
        step();
        check_value("w4_f_1", {59'd0, co4, s4}, {59'd0, 1'b1, 4'h0});
        a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
        step();
        check_value("w4_max", {59'd0, co4, s4}, {59'd0, 1'b1, 4'hF});
        check_value("w4_max_vld", {63'd0, ov4}, 64'd1);

        // Asynchronous reset between edges while sum=A
        a4 = 4'h5; b4 = 4'h5; c4 = 1'b0;
        step();
        check_value("w4_pre_rst", {59'd0, co4, s4}, {59'd0, 1'b0, 4'hA});
        v4 = 1'b0;
        #2 sys_rst = 1'b1;
        #1;
        check_value("async_rst", {58'd0, ov4, co4, s4}, 64'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        a4 = 4'h3; b4 = 4'h4; c4 = 1'b0; v4 = 1'b1;
        step();
        check_value("post_rst", {58'd0, ov4, co4, s4}, {58'd0, 1'b1, 1'b0, 4'h7});

        // Hold with in_valid low and changing operands
        a4 = 4'h2; b4 = 4'h3; c4 = 1'b0;
        step();
        check_value("hold_load", {59'd0, co4, s4}, {59'd0, 1'b0, 4'h5});
        v4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a4 = 4'(i + 9); b4 = 4'(3 * i + 7); c4 = i[0];
            step();
            check_value($sformatf("hold_%0d", i), {58'd0, ov4, co4, s4},
                        {58'd0, 1'b0, 1'b0, 4'h5});
        end

        // WIDTH=8 random stream against a delayed 9-bit model
        exp8   = 9'd0;
        exp_v8 = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            c8 = 1'($urandom);
            v8 = 1'($urandom_range(0, 1));
            if (v8) begin
                exp8   = {1'b0, a8} + {1'b0, b8} + {8'd0, c8};
                exp_v8 = 1'b1;
            end else begin
                exp_v8 = 1'b0;
            end
            step();
            res8 = {co8, s8};
            check_value($sformatf("rnd_res_%0d", i), {55'd0, res8}, {55'd0, exp8});
            check_value($sformatf("rnd_vld_%0d", i), {63'd0, ov8}, {63'd0, exp_v8});
        end
        v8 = 1'b0;

`ifdef FULL_ADDER_OVF_EN
        // Signed overflow at WIDTH=4
        a4 = 4'h7; b4 = 4'h1; c4 = 1'b0; v4 = 1'b1;
        step();
        check_value("ovf_7_1", {58'd0, of4, co4, s4}, {58'd0, 1'b1, 1'b0, 4'h8});
        a4 = 4'hF; b4 = 4'h1; c4 = 1'b0;
        step();
        check_value("ovf_f_1", {58'd0, of4, co4, s4}, {58'd0, 1'b0, 1'b1, 4'h0});
        a4 = 4'h7; b4 = 4'h1;
        step();
        v4 = 1'b0;
        step();
        check_value("ovf_hold", {63'd0, of4}, 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
